lsu_bus_master: RTL and testbench

Load/store initiator sitting between the MEM pipeline stage and the data-memory bus. It takes one load or store per operation and checks alignment. It drives a word-aligned bus request with byte enables and lane-replicated write data, then waits for the memory's acknowledge. It then returns lane-extracted, sign- or zero-extended load data, or an address/bus exception, to the pipeline.

---
 rtl/lsu_bus_master.sv | 195 +++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
`default_nettype none
// ============================================================================
// lsu_bus_master : load/store initiator between the MEM stage and data bus
// Revision 1.0   : initial release
// ============================================================================
module lsu_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [1:0]  op_width,
  input  logic        op_sign,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [4:0] C_ADEL     = 5'd4;
  localparam logic [4:0] C_ADES     = 5'd5;
  localparam logic [4:0] C_DBE      = 5'd7;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic [1:0]  r_lane, w_lane_nx;
  logic [1:0]  r_width, w_width_nx;
  logic        r_sign, w_sign_nx;
  logic        w_req_nx, w_we_nx, w_exc_nx;
  logic [3:0]  w_be_nx;
  logic [31:0] w_addr_nx, w_wdata_nx, w_rdata_nx;
  logic [4:0]  w_code_nx;

  logic        w_misaligned;
  logic [3:0]  w_op_be;
  logic [31:0] w_op_wdata;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_load_data;

  assign busy = (r_state != IDLE);
  assign done = (r_state == RESP);

  // Request shaping from the pipeline operands.
  always_comb begin
    w_misaligned = (op_width == 2'b11)
                 | ((op_width == 2'b00) & (op_addr[1:0] != 2'b00))
                 | ((op_width == 2'b01) & op_addr[0]);
    case (op_width)
      2'b10: begin
        w_op_be    = 4'b0001 << op_addr[1:0];
        w_op_wdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        w_op_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        w_op_wdata = {2{op_wdata[15:0]}};
      end
      default: begin
        w_op_be    = 4'b1111;
        w_op_wdata = op_wdata;
      end
    endcase
  end

  // Lane extraction uses the offset captured at accept time.
  always_comb begin
    w_rd_byte = bus_rdata[{r_lane, 3'b000} +: 8];
    w_rd_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_width)
      2'b10:   w_load_data = {{24{r_sign & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_load_data = {{16{r_sign & w_rd_half[15]}}, w_rd_half};
      default: w_load_data = bus_rdata;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_lane_nx  = r_lane;
    w_width_nx = r_width;
    w_sign_nx  = r_sign;
    w_req_nx   = bus_req;
    w_we_nx    = bus_we;
    w_be_nx    = bus_be;
    w_addr_nx  = bus_addr;
    w_wdata_nx = bus_wdata;
    w_rdata_nx = rdata;
    w_exc_nx   = exc;
    w_code_nx  = exc_code;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          if (w_misaligned) begin
            w_state_nx = RESP;
            w_rdata_nx = 32'd0;
            w_exc_nx   = 1'b1;
            w_code_nx  = op_we ? C_ADES : C_ADEL;
          end else begin
            w_state_nx = REQ;
            w_cnt_nx   = 8'd0;
            w_lane_nx  = op_addr[1:0];
            w_width_nx = op_width;
            w_sign_nx  = op_sign;
            w_req_nx   = 1'b1;
            w_we_nx    = op_we;
            w_be_nx    = w_op_be;
            w_addr_nx  = {op_addr[31:2], 2'b00};
            w_wdata_nx = w_op_wdata;
          end
        end
      end
      REQ: begin
        // Acknowledge takes priority over an expiring timeout.
        if (bus_ack || (r_cnt == C_CNT_LAST)) begin
          w_state_nx = RESP;
          w_req_nx   = 1'b0;
          w_we_nx    = 1'b0;
          w_be_nx    = 4'd0;
          w_addr_nx  = 32'd0;
          w_wdata_nx = 32'd0;
          if (bus_ack) begin
            w_rdata_nx = bus_we ? 32'd0 : w_load_data;
            w_exc_nx   = 1'b0;
            w_code_nx  = 5'd0;
          end else begin
            w_rdata_nx = 32'd0;
            w_exc_nx   = 1'b1;
            w_code_nx  = C_DBE;
          end
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      RESP: begin
        w_state_nx = IDLE;
        w_rdata_nx = 32'd0;
        w_exc_nx   = 1'b0;
        w_code_nx  = 5'd0;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_lane    <= 2'd0;
      r_width   <= 2'd0;
      r_sign    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      exc       <= 1'b0;
      exc_code  <= 5'd0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_lane    <= w_lane_nx;
      r_width   <= w_width_nx;
      r_sign    <= w_sign_nx;
      bus_req   <= w_req_nx;
      bus_we    <= w_we_nx;
      bus_be    <= w_be_nx;
      bus_addr  <= w_addr_nx;
      bus_wdata <= w_wdata_nx;
      rdata     <= w_rdata_nx;
      exc       <= w_exc_nx;
      exc_code  <= w_code_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// ============================================================================
// tb_lsu_bus_master : scoreboard bench with a memory responder and ref model
// Revision 1.0      : initial release
// ============================================================================
module tb_lsu_bus_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_we, op_sign;
  logic [1:0]  op_width;
  logic [31:0] op_addr, op_wdata;
  logic        busy, done, exc;
  logic [31:0] rdata;
  logic [4:0]  exc_code;
  logic        bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  lsu_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_we(op_we),
    .op_width(op_width), .op_sign(op_sign), .op_addr(op_addr), .op_wdata(op_wdata),
    .busy(busy), .done(done), .rdata(rdata), .exc(exc), .exc_code(exc_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          nreq;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    int          lat;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int tests = 0;
  int fails = 0;
  int          plan_delay = 0;
  logic [31:0] plan_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size, alignment and lane arithmetic.
  function automatic void model(input logic we, input logic [1:0] width, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mem, input int delay,
                                output logic aligned, output req_t rq, output rsp_t rs);
    int size, lane;
    logic [63:0] mask, v;
    size    = (width == 2'd0) ? 4 : (width == 2'd1) ? 2 : 1;
    lane    = int'(addr[1:0]);
    aligned = (width != 2'd3) && ((addr % 32'(size)) == 32'd0);
    mask    = (64'd1 << (8 * size)) - 64'd1;
    rq.addr = addr & ~32'd3;
    rq.we   = we;
    rq.be   = 4'(((1 << size) - 1) << lane);
    v = {32'd0, wdata} & mask;
    if (size == 1) v = v * 64'h0101_0101;
    else if (size == 2) v = v * 64'h0001_0001;
    rq.wdata = v[31:0];
    rq.nreq  = (delay >= TO) ? TO : delay + 1;
    if (!aligned) begin
      rs.rdata = 32'd0; rs.exc = 1'b1; rs.code = we ? 5'd5 : 5'd4; rs.lat = 1;
    end else if (delay >= TO) begin
      rs.rdata = 32'd0; rs.exc = 1'b1; rs.code = 5'd7; rs.lat = TO + 1;
    end else begin
      rs.exc = 1'b0; rs.code = 5'd0; rs.lat = delay + 2;
      v = ({32'd0, mem} >> (8 * lane)) & mask;
      if (sgn && size < 4 && v[8 * size - 1]) v = v | ~mask;
      rs.rdata = we ? 32'd0 : v[31:0];
    end
  endfunction

  // Memory responder: acks after plan_delay extra request cycles.
  initial begin
    int req_cyc;
    req_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        bus_ack   = (req_cyc == plan_delay);
        bus_rdata = bus_ack ? plan_rdata : $urandom;
        req_cyc++;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        req_cyc   = 0;
      end
    end
  end

  // Request monitor.
  req_t cur_req;
  int   req_len = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (bus_req === 1'b1 && !prev_req) begin
      if (exp_req.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: bus_req=1 at %0t, required 0", $time);
      end else begin
        cur_req = exp_req.pop_front();
        check("bus_addr", bus_addr, cur_req.addr);
        check("bus_we", 32'(bus_we), 32'(cur_req.we));
        check("bus_be", 32'(bus_be), 32'(cur_req.be));
        if (cur_req.we) check("bus_wdata", bus_wdata, cur_req.wdata);
      end
      req_len = 1;
    end else if (bus_req === 1'b1) begin
      req_len++;
    end else if (prev_req) begin
      check("req_len", req_len, cur_req.nreq);
      check("bus_fields_idle", bus_addr | bus_wdata | 32'({bus_we, bus_be}), 32'd0);
    end
    prev_req = (bus_req === 1'b1);
  end

  // Response monitor.
  rsp_t cur_rsp;
  int   lat = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1 && !prev_busy) lat = 1;
    else if (busy === 1'b1) lat++;
    if (done === 1'b1) begin
      if (exp_rsp.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: done=1 at %0t, required 0", $time);
      end else begin
        cur_rsp = exp_rsp.pop_front();
        check("rdata", rdata, cur_rsp.rdata);
        check("exc", 32'(exc), 32'(cur_rsp.exc));
        check("exc_code", 32'(exc_code), 32'(cur_rsp.code));
        check("latency", lat, cur_rsp.lat);
      end
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic run_op(input logic we, input logic [1:0] width, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mem, input int delay);
    logic al;
    req_t rq;
    rsp_t rs;
    bit   got;
    model(we, width, sgn, addr, wdata, mem, delay, al, rq, rs);
    if (al) exp_req.push_back(rq);
    exp_rsp.push_back(rs);
    plan_delay = delay; plan_rdata = mem;
    op_we = we; op_width = width; op_sign = sgn; op_addr = addr; op_wdata = wdata;
    op_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = (done === 1'b1);
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within 60 cycles, required done");
    end
    if ($urandom_range(0, 3) == 0) begin
      op_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_width = 2'd0; op_sign = 1'b0;
    op_addr = 32'd0; op_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({busy, done, bus_req, bus_we, bus_be, exc, exc_code}), 32'd0);
    check("reset_data", bus_addr | bus_wdata | rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h8765_4321, 1);
    run_op(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 32'h80FF_1234, 0);
    run_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h80FF_1234, 0);
    run_op(1'b1, 2'b01, 1'b0, 32'h0E, 32'hDEAD_BEEF, 32'h0, 2);
    run_op(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 32'h0, 0);
    run_op(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234, 32'h0, 0);
    run_op(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 0);
    run_op(1'b1, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 0);
    run_op(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 10);
    run_op(1'b1, 2'b00, 1'b0, 32'h44, 32'hCAFE_F00D, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
             $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    // Reset during the second request cycle while the memory acknowledges.
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    begin
      req_t rq;
      rq.addr = 32'h20; rq.we = 1'b0; rq.be = 4'hF; rq.wdata = 32'd0; rq.nreq = 2;
      exp_req.push_back(rq);
    end
    plan_delay = 1; plan_rdata = 32'h5A5A_5A5A;
    op_we = 1'b0; op_width = 2'b00; op_sign = 1'b0; op_addr = 32'h20; op_valid = 1'b1;
    for (int k = 0; k < 10 && bus_req !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", 32'({busy, done, bus_req, bus_we, bus_be, exc, exc_code}), 32'd0);
    check("midreset_data", bus_addr | bus_wdata | rdata, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("exp_req_left", exp_req.size(), 32'd0);
    check("exp_rsp_left", exp_rsp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
